// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: CSR read/write ports, mie/mip interrupt
// select, trap entry/exit sequencing and 64-bit mcycle/minstret counters.
module csr_trap_unit #(
  parameter int              XLEN         = 32,
  parameter int              NUM_IRQ      = 16,
  parameter logic [XLEN-1:0] MTVEC_RESET  = '0,
  parameter bit              HAS_MINSTRET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [11:0]         csr_raddr,
  output logic [XLEN-1:0]     csr_rdata,
  output logic                csr_illegal,
  input  logic                wb_en,
  input  logic [1:0]          wb_op,
  input  logic [11:0]         wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                instret_inc,
  input  logic [NUM_IRQ-1:0]  irq_i,
  output logic                irq_req,
  output logic [3:0]          irq_index,
  input  logic                trap_entry_en,
  input  logic                trap_exit_en,
  input  logic [XLEN-1:0]     normal_pc,
  output logic [XLEN-1:0]     trap_entry_pc,
  output logic [XLEN-1:0]     restore_pc
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;

  logic                mstatus_mie_q, mstatus_mie_d;
  logic                mstatus_mpie_q, mstatus_mpie_d;
  logic [NUM_IRQ-1:0]  mie_q, mie_d;
  logic [NUM_IRQ-1:0]  mip_q, mip_d;
  logic [XLEN-1:0]     mtvec_q, mtvec_d;
  logic [XLEN-1:0]     mscratch_q, mscratch_d;
  logic [XLEN-1:0]     mepc_q, mepc_d;
  logic [XLEN-1:0]     mcause_q, mcause_d;
  logic [63:0]         mcycle_q, mcycle_d;
  logic [63:0]         minstret_q, minstret_d;

  logic [XLEN-1:0]     mstatus_val;
  logic [XLEN-1:0]     rd_val, wb_old, wb_raw, wb_masked;
  logic                rd_hit, wb_mapped, wb_hit;
  logic [NUM_IRQ-1:0]  irq_pend;

  assign mstatus_val = XLEN'({mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000});

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b1;
    case (csr_raddr)
      A_MSTATUS:   rd_val = mstatus_val;
      A_MIE:       rd_val = XLEN'(mie_q);
      A_MTVEC:     rd_val = mtvec_q;
      A_MSCRATCH:  rd_val = mscratch_q;
      A_MEPC:      rd_val = mepc_q;
      A_MCAUSE:    rd_val = mcause_q;
      A_MIP:       rd_val = XLEN'(mip_q);
      A_MCYCLE:    rd_val = XLEN'(mcycle_q[31:0]);
      A_MCYCLEH:   rd_val = XLEN'(mcycle_q[63:32]);
      A_MINSTRET:  begin rd_val = XLEN'(minstret_q[31:0]);  rd_hit = HAS_MINSTRET; end
      A_MINSTRETH: begin rd_val = XLEN'(minstret_q[63:32]); rd_hit = HAS_MINSTRET; end
      default:     rd_hit = 1'b0;
    endcase
  end

  // Current value of the writeback target, the operand of RS/RC.
  always_comb begin
    wb_old    = '0;
    wb_mapped = 1'b1;
    case (wb_addr)
      A_MSTATUS:   wb_old = mstatus_val;
      A_MIE:       wb_old = XLEN'(mie_q);
      A_MTVEC:     wb_old = mtvec_q;
      A_MSCRATCH:  wb_old = mscratch_q;
      A_MEPC:      wb_old = mepc_q;
      A_MCAUSE:    wb_old = mcause_q;
      A_MIP:       wb_old = XLEN'(mip_q);
      A_MCYCLE:    wb_old = XLEN'(mcycle_q[31:0]);
      A_MCYCLEH:   wb_old = XLEN'(mcycle_q[63:32]);
      A_MINSTRET:  begin wb_old = XLEN'(minstret_q[31:0]);  wb_mapped = HAS_MINSTRET; end
      A_MINSTRETH: begin wb_old = XLEN'(minstret_q[63:32]); wb_mapped = HAS_MINSTRET; end
      default:     wb_mapped = 1'b0;
    endcase
  end

  always_comb begin
    case (wb_op)
      2'b01:   wb_raw = wb_data;
      2'b10:   wb_raw = wb_old | wb_data;
      2'b11:   wb_raw = wb_old & ~wb_data;
      default: wb_raw = wb_old;
    endcase
    wb_masked = wb_raw;
    case (wb_addr)
      A_MSTATUS: wb_masked = wb_raw & XLEN'(32'h88);
      A_MIE:     wb_masked = XLEN'(wb_raw[NUM_IRQ-1:0]);
      A_MTVEC:   wb_masked = wb_raw & ~XLEN'(32'h2);
      A_MEPC:    wb_masked = wb_raw & ~XLEN'(32'h3);
      A_MIP:     wb_masked = wb_old;
      default:   wb_masked = wb_raw;
    endcase
    wb_hit = wb_en && (wb_op != 2'b00) && wb_mapped && (wb_addr != A_MIP);
  end

  // Unmapped reads are forced to zero; a same-cycle write to the read address is bypassed.
  always_comb begin
    csr_illegal = !rd_hit;
    if (!rd_hit)
      csr_rdata = '0;
    else if (wb_hit && (wb_addr == csr_raddr))
      csr_rdata = wb_masked;
    else
      csr_rdata = rd_val;
  end

  // Lowest line number has highest priority, so scan downwards and keep the last hit.
  always_comb begin
    irq_pend  = mip_q & mie_q;
    irq_index = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) irq_index = 4'(i);
    end
    irq_req = mstatus_mie_q && (|irq_pend);
  end

  always_comb begin
    trap_entry_pc = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[0]) trap_entry_pc = {mtvec_q[XLEN-1:2], 2'b00} + XLEN'({irq_index, 2'b00});
    restore_pc = mepc_q;
  end

  // Trap sequencing is applied after the CSR write so it overrides the fields it owns.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mip_d          = irq_i;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mcycle_d       = mcycle_q + 64'd1;
    minstret_d     = HAS_MINSTRET ? (minstret_q + 64'(instret_inc)) : minstret_q;
    if (wb_hit) begin
      case (wb_addr)
        A_MSTATUS:   begin mstatus_mie_d = wb_masked[3]; mstatus_mpie_d = wb_masked[7]; end
        A_MIE:       mie_d = wb_masked[NUM_IRQ-1:0];
        A_MTVEC:     mtvec_d = wb_masked;
        A_MSCRATCH:  mscratch_d = wb_masked;
        A_MEPC:      mepc_d = wb_masked;
        A_MCAUSE:    mcause_d = wb_masked;
        A_MCYCLE:    mcycle_d = {mcycle_q[63:32], wb_masked[31:0]};
        A_MCYCLEH:   mcycle_d = {wb_masked[31:0], mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], wb_masked[31:0]};
        A_MINSTRETH: minstret_d = {wb_masked[31:0], minstret_q[31:0]};
        default:     ;
      endcase
    end
    if (trap_entry_en) begin
      mepc_d         = normal_pc & ~XLEN'(32'h3);
      mcause_d       = {1'b1, {(XLEN-5){1'b0}}, irq_index};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
    end else if (trap_exit_en) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mip_q          <= '0;
      mtvec_q        <= {MTVEC_RESET[XLEN-1:2], 1'b0, MTVEC_RESET[0]};
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mcycle_q       <= '0;
      minstret_q     <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mip_q          <= mip_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed self-checking bench for csr_trap_unit: CSR ops, bypass, interrupts,
// trap entry/exit, counters and asynchronous reset.
module tb_csr_trap_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0803;
  localparam logic [1:0] OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11;
  localparam logic [11:0] MAP_ADDR [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                            12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82};

  logic        clk, rst;
  logic [11:0] csr_raddr, wb_addr;
  logic [31:0] csr_rdata, wb_data, normal_pc, trap_entry_pc, restore_pc;
  logic        csr_illegal, wb_en, instret_inc, irq_req, trap_entry_en, trap_exit_en;
  logic [1:0]  wb_op;
  logic [15:0] irq_i;
  logic [3:0]  irq_index;

  int errors = 0;
  int checks = 0;

  csr_trap_unit #(.XLEN(32), .NUM_IRQ(16), .MTVEC_RESET(MTVEC_RST), .HAS_MINSTRET(1'b1)) dut (
    .clk(clk), .rst(rst), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .wb_en(wb_en), .wb_op(wb_op), .wb_addr(wb_addr), .wb_data(wb_data), .instret_inc(instret_inc),
    .irq_i(irq_i), .irq_req(irq_req), .irq_index(irq_index), .trap_entry_en(trap_entry_en),
    .trap_exit_en(trap_exit_en), .normal_pc(normal_pc), .trap_entry_pc(trap_entry_pc),
    .restore_pc(restore_pc)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] timeout");
  end

  // Drive one CSR write for exactly one rising edge; called from the low clock phase.
  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_op = op; wb_addr = a; wb_data = d;
    @(negedge clk);
    wb_en = 1'b0; wb_op = 2'b00;
  endtask

  task automatic rd(input logic [11:0] a);
    csr_raddr = a;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    for (int i = 0; i < 11; i++) begin
      exp = (MAP_ADDR[i] == 12'h305) ? 32'h0000_0801 : 32'h0;
      rd(MAP_ADDR[i]);
      checks++; if (csr_rdata !== exp || csr_illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_read addr=%h got=%h ill=%b exp=%h ill=0", MAP_ADDR[i], csr_rdata, csr_illegal, exp); end
    end
    rd(12'h7C0);
    checks++; if (csr_rdata !== 32'h0 || csr_illegal !== 1'b1) begin errors++; $display("[TB] FAIL unmapped_read got=%h ill=%b exp=0 ill=1", csr_rdata, csr_illegal); end
    checks++; if (irq_req !== 1'b0 || irq_index !== 4'd0) begin errors++; $display("[TB] FAIL reset_irq got=%b/%0d exp=0/0", irq_req, irq_index); end
    checks++; if (restore_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_restore_pc got=%h exp=0", restore_pc); end
    checks++; if (trap_entry_pc !== 32'h800) begin errors++; $display("[TB] FAIL reset_entry_pc got=%h exp=800", trap_entry_pc); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_csr_ops();
    wr(OP_RW, 12'h300, 32'hFFFF_FFFF);
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h88) begin errors++; $display("[TB] FAIL mstatus_rw got=%h exp=88", csr_rdata); end
    wb_en = 1'b1; wb_op = OP_RC; wb_addr = 12'h300; wb_data = 32'h8; csr_raddr = 12'h300;
    #1;
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("[TB] FAIL mstatus_bypass got=%h exp=80", csr_rdata); end
    @(negedge clk);
    wb_en = 1'b0; wb_op = 2'b00;
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("[TB] FAIL mstatus_rc got=%h exp=80", csr_rdata); end
    wr(OP_RW, 12'h340, 32'hA5A5_0F0F);
    wr(OP_RS, 12'h340, 32'h0000_F000);
    rd(12'h340);
    checks++; if (csr_rdata !== 32'hA5A5_FF0F) begin errors++; $display("[TB] FAIL mscratch_rs got=%h exp=a5a5ff0f", csr_rdata); end
    wr(OP_RC, 12'h340, 32'hA500_0000);
    rd(12'h340);
    checks++; if (csr_rdata !== 32'h00A5_FF0F) begin errors++; $display("[TB] FAIL mscratch_rc got=%h exp=00a5ff0f", csr_rdata); end
    wb_en = 1'b1; wb_op = OP_RW; wb_addr = 12'h304; wb_data = 32'hFFFF_FFFF; csr_raddr = 12'h304;
    #1;
    checks++; if (csr_rdata !== 32'h0000_FFFF) begin errors++; $display("[TB] FAIL mie_bypass got=%h exp=0000ffff", csr_rdata); end
    @(negedge clk);
    wb_en = 1'b0; wb_op = 2'b00;
    rd(12'h304);
    checks++; if (csr_rdata !== 32'h0000_FFFF) begin errors++; $display("[TB] FAIL mie_mask got=%h exp=0000ffff", csr_rdata); end
    wr(OP_RW, 12'h344, 32'h0000_FFFF);
    rd(12'h344);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mip_readonly got=%h exp=0", csr_rdata); end
    wr(OP_RW, 12'h7C0, 32'h1234);
    rd(12'h7C0);
    checks++; if (csr_rdata !== 32'h0 || csr_illegal !== 1'b1) begin errors++; $display("[TB] FAIL unmapped_write got=%h ill=%b exp=0 ill=1", csr_rdata, csr_illegal); end
    wr(OP_RW, 12'h341, 32'h0000_0123);
    rd(12'h341);
    checks++; if (csr_rdata !== 32'h120 || restore_pc !== 32'h120) begin errors++; $display("[TB] FAIL mepc_mask got=%h/%h exp=120", csr_rdata, restore_pc); end
  endtask

  task automatic test_irq();
    wr(OP_RW, 12'h304, 32'h24);
    wr(OP_RS, 12'h300, 32'h8);
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h88) begin errors++; $display("[TB] FAIL mstatus_rs got=%h exp=88", csr_rdata); end
    irq_i = 16'h0024;
    #1;
    checks++; if (irq_req !== 1'b0) begin errors++; $display("[TB] FAIL irq_latency got=%b exp=0", irq_req); end
    tick();
    checks++; if (irq_req !== 1'b1 || irq_index !== 4'd2) begin errors++; $display("[TB] FAIL irq_take got=%b/%0d exp=1/2", irq_req, irq_index); end
    rd(12'h344);
    checks++; if (csr_rdata !== 32'h24) begin errors++; $display("[TB] FAIL mip_read got=%h exp=24", csr_rdata); end
    wr(OP_RC, 12'h300, 32'h8);
    checks++; if (irq_req !== 1'b0 || irq_index !== 4'd2) begin errors++; $display("[TB] FAIL irq_gmask got=%b/%0d exp=0/2", irq_req, irq_index); end
    wr(OP_RS, 12'h300, 32'h8);
    wr(OP_RW, 12'h304, 32'h20);
    checks++; if (irq_req !== 1'b1 || irq_index !== 4'd5) begin errors++; $display("[TB] FAIL irq_line5 got=%b/%0d exp=1/5", irq_req, irq_index); end
    wr(OP_RW, 12'h304, 32'h0);
    checks++; if (irq_req !== 1'b0 || irq_index !== 4'd0) begin errors++; $display("[TB] FAIL irq_mie_mask got=%b/%0d exp=0/0", irq_req, irq_index); end
    wr(OP_RW, 12'h304, 32'h20);
  endtask

  task automatic test_trap_entry();
    wr(OP_RW, 12'h305, 32'h1003);
    rd(12'h305);
    checks++; if (csr_rdata !== 32'h1001) begin errors++; $display("[TB] FAIL mtvec_mask got=%h exp=1001", csr_rdata); end
    checks++; if (trap_entry_pc !== 32'h1014) begin errors++; $display("[TB] FAIL vectored_pc got=%h exp=1014", trap_entry_pc); end
    trap_entry_en = 1'b1; normal_pc = 32'h203;
    tick();
    trap_entry_en = 1'b0;
    checks++; if (restore_pc !== 32'h200) begin errors++; $display("[TB] FAIL entry_mepc got=%h exp=200", restore_pc); end
    rd(12'h342);
    checks++; if (csr_rdata !== 32'h8000_0005) begin errors++; $display("[TB] FAIL entry_mcause got=%h exp=80000005", csr_rdata); end
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h80) begin errors++; $display("[TB] FAIL entry_mstatus got=%h exp=80", csr_rdata); end
    wr(OP_RW, 12'h305, 32'h1000);
    checks++; if (trap_entry_pc !== 32'h1000) begin errors++; $display("[TB] FAIL direct_pc got=%h exp=1000", trap_entry_pc); end
  endtask

  task automatic test_trap_exit();
    trap_exit_en = 1'b1;
    tick();
    trap_exit_en = 1'b0;
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h88) begin errors++; $display("[TB] FAIL exit_mstatus got=%h exp=88", csr_rdata); end
  endtask

  task automatic test_simultaneous();
    trap_entry_en = 1'b1; trap_exit_en = 1'b1; normal_pc = 32'h40;
    tick();
    trap_entry_en = 1'b0; trap_exit_en = 1'b0;
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h80 || restore_pc !== 32'h40) begin errors++; $display("[TB] FAIL entry_exit got=%h/%h exp=80/40", csr_rdata, restore_pc); end
    wr(OP_RW, 12'h300, 32'h88);
    trap_entry_en = 1'b1; normal_pc = 32'h300;
    wr(OP_RW, 12'h300, 32'h0);
    trap_entry_en = 1'b0;
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h80 || restore_pc !== 32'h300) begin errors++; $display("[TB] FAIL entry_vs_write got=%h/%h exp=80/300", csr_rdata, restore_pc); end
    trap_entry_en = 1'b1; normal_pc = 32'h444;
    wr(OP_RW, 12'h341, 32'h5554);
    trap_entry_en = 1'b0;
    rd(12'h300);
    checks++; if (csr_rdata !== 32'h0 || restore_pc !== 32'h444) begin errors++; $display("[TB] FAIL entry_vs_mepc got=%h/%h exp=0/444", csr_rdata, restore_pc); end
  endtask

  task automatic test_counters();
    wr(OP_RW, 12'hB80, 32'h0);
    wr(OP_RW, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mcycle_lo_write got=%h exp=ffffffff", csr_rdata); end
    tick();
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mcycle_carry_lo got=%h exp=0", csr_rdata); end
    rd(12'hB80);
    checks++; if (csr_rdata !== 32'h1) begin errors++; $display("[TB] FAIL mcycle_carry_hi got=%h exp=1", csr_rdata); end
    wr(OP_RW, 12'hB80, 32'hFFFF_FFFF);
    wr(OP_RW, 12'hB00, 32'hFFFF_FFFF);
    rd(12'hB80);
    checks++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mcycle_hi_write got=%h exp=ffffffff", csr_rdata); end
    tick();
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mcycle_wrap_lo got=%h exp=0", csr_rdata); end
    rd(12'hB80);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("[TB] FAIL mcycle_wrap_hi got=%h exp=0", csr_rdata); end
    instret_inc = 1'b1;
    wr(OP_RW, 12'hB02, 32'h1234);
    rd(12'hB02);
    checks++; if (csr_rdata !== 32'h1234) begin errors++; $display("[TB] FAIL minstret_write got=%h exp=1234", csr_rdata); end
    tick();
    rd(12'hB02);
    checks++; if (csr_rdata !== 32'h1235) begin errors++; $display("[TB] FAIL minstret_inc got=%h exp=1235", csr_rdata); end
    wr(OP_RW, 12'hB82, 32'h7);
    rd(12'hB02);
    checks++; if (csr_rdata !== 32'h1235) begin errors++; $display("[TB] FAIL minstreth_hold got=%h exp=1235", csr_rdata); end
    rd(12'hB82);
    checks++; if (csr_rdata !== 32'h7) begin errors++; $display("[TB] FAIL minstreth_write got=%h exp=7", csr_rdata); end
    instret_inc = 1'b0;
    tick();
    rd(12'hB02);
    checks++; if (csr_rdata !== 32'h1235) begin errors++; $display("[TB] FAIL minstret_idle got=%h exp=1235", csr_rdata); end
  endtask

  task automatic test_reset_mid();
    #3;
    rst = 1'b1;
    #1;
    checks++; if (restore_pc !== 32'h0 || irq_req !== 1'b0 || irq_index !== 4'd0) begin errors++; $display("[TB] FAIL async_reset_out got=%h/%b/%0d exp=0/0/0", restore_pc, irq_req, irq_index); end
    rd(12'h340);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_mscratch got=%h exp=0", csr_rdata); end
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_mcycle got=%h exp=0", csr_rdata); end
    rd(12'h305);
    checks++; if (csr_rdata !== 32'h801) begin errors++; $display("[TB] FAIL async_reset_mtvec got=%h exp=801", csr_rdata); end
    tick();
    rst = 1'b0;
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'h0) begin errors++; $display("[TB] FAIL release_mcycle got=%h exp=0", csr_rdata); end
    tick();
    rd(12'hB00);
    checks++; if (csr_rdata !== 32'h1) begin errors++; $display("[TB] FAIL first_count got=%h exp=1", csr_rdata); end
  endtask

  initial begin
    rst = 1'b1; csr_raddr = '0; wb_en = 1'b0; wb_op = 2'b00; wb_addr = '0; wb_data = '0;
    instret_inc = 1'b0; irq_i = '0; trap_entry_en = 1'b0; trap_exit_en = 1'b0; normal_pc = '0;
    @(negedge clk);
    test_reset();
    test_csr_ops();
    test_irq();
    test_trap_entry();
    test_trap_exit();
    test_simultaneous();
    test_counters();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
